vrisc_controller: RTL and testbench
===================================

# vrisc_controller

- Eight-phase instruction sequencer for the 8-bit RISC CPU.
- Sits upstream of the ALU and accumulator: decodes the 3-bit opcode held in the instruction register and emits the memory, PC, IR, accumulator and bus-enable strobes for each instruction.
- Consumes the ALU's `is_zero` flag to resolve SKZ.
- Supplies the opcode that the ALU and the rest of the datapath act on.

## Interface
Parameters:
- None. Opcode encodings come from `src/defines.v`: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  3  current instruction opcode from IR
- `zero`  in  1  accumulator-zero flag (ALU `is_zero`)
- `sel`  out  1  1 = PC drives address bus, 0 = IR operand field
- `rd`  out  1  memory read strobe
- `ld_ir`  out  1  load instruction register
- `inc_pc`  out  1  increment program counter
- `halt`  out  1  CPU halted
- `ld_pc`  out  1  load PC from IR operand (jump)
- `data_e`  out  1  drive accumulator onto data bus
- `ld_ac`  out  1  load accumulator from ALU `out`
- `wr`  out  1  memory write strobe
- `phase`  out  3  current phase, 0..7

## Operation
- The 3-bit `phase` register steps 0→1→…→7→0 once per clock.
- Phases, in order: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- A sticky `halted` register is set by HLT; only reset clears it.
- `aluop` = opcode ∈ {ADD, AND, XOR, LDA}.
- Strobes are combinational from `phase`, `opcode`, `zero` and `halted`. Any strobe not listed for a phase is 0.
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc; halt = (opcode==HLT).
  - OP_FETCH: rd = aluop.
  - ALU_OP: rd = aluop; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - STORE: rd = aluop; ld_ac = aluop; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- HLT handling:
  - At the OP_ADDR clock edge with opcode==HLT, `halted` is set and `phase` stays at OP_ADDR.
  - While halted: `halt`=1, every other strobe 0 (including inc_pc), and `phase` is frozen.
- `wr` and `ld_ac` are never both 1.
- `ld_pc` is asserted only for JMP.

## Timing
- Reset (rst_n low, asynchronous): `phase`=0 (INST_ADDR), `halted`=0.
- Outputs during reset: sel=1, all other strobes 0, `phase`=0.
- Reset release: first rising edge with rst_n high advances to INST_FETCH.
- Latency: one instruction = 8 clocks, fixed for all opcodes except HLT.
- HLT:
  - `halt` rises in OP_ADDR, cycle 4 of the instruction.
  - inc_pc is high in that cycle only.
  - `halt` stays high until reset.
- `opcode` must be stable from the edge that ends INST_LOAD through STORE.
- `zero` is sampled combinationally during ALU_OP only.
- Wrap: after STORE, `phase` returns to INST_ADDR with no gap cycle.
- Reset mid-instruction: immediate return to INST_ADDR outputs. No partial wr/ld_ac is held.

## Configuration
- `VRISC_CTRL_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - `phase` holds at INST_ADDR until `step` is sampled high on a rising edge, so exactly one instruction runs per accepted `step`.
  - `step` held high runs continuously.
  - `step` is ignored in all other phases and while halted.
- Not defined: no `step` port; the sequencer free-runs.

## Test plan
- Reset:
  - Assert rst_n=0 mid-phase 5 → phase=0, sel=1, others 0 immediately (asynchronous).
  - Release → phase 1 on the next edge.
- ADD (opcode=2):
  - 8 clocks → rd high in phases 1–3 and 5–7; ld_ir in 2–3; inc_pc in 4; ld_ac only in 7.
  - wr, ld_pc, data_e never 1.
- STO (opcode=6):
  - data_e in phases 6–7, wr only in phase 7.
  - rd low in 5–7; ld_ac never 1.
- SKZ (opcode=1):
  - zero=1 → inc_pc in phases 4 and 6.
  - zero=0 → inc_pc in phase 4 only.
- JMP (7) → ld_pc in phases 6–7, no rd in phases 5–7.
- HLT (0):
  - halt rises in phase 4; inc_pc high for one cycle.
  - phase stays 4 for 20 further clocks with all other strobes 0.
  - Reset → resumes at phase 0.
- With `VRISC_CTRL_STEP_EN`: step=0 holds phase 0 for 10 clocks; a one-cycle step pulse → exactly one 8-cycle instruction, then hold at phase 0.

Source files
------------

// File: rtl/vrisc_controller.sv
// Eight-phase instruction sequencer for the 8-bit RISC CPU: steps through fetch/execute phases
// and decodes the IR opcode into bus/memory/PC/accumulator strobes. Option: VRISC_CTRL_STEP_EN.
module vrisc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode_i,
    input  logic       zero_i,
`ifdef VRISC_CTRL_STEP_EN
    input  logic       step_i,
`endif
    output logic       sel_o,
    output logic       rd_o,
    output logic       ld_ir_o,
    output logic       inc_pc_o,
    output logic       halt_o,
    output logic       ld_pc_o,
    output logic       data_e_o,
    output logic       ld_ac_o,
    output logic       wr_o,
    output logic [2:0] phase_o
);

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    typedef enum logic [2:0] {
        StInstAddr  = 3'd0,
        StInstFetch = 3'd1,
        StInstLoad  = 3'd2,
        StIdle      = 3'd3,
        StOpAddr    = 3'd4,
        StOpFetch   = 3'd5,
        StAluOp     = 3'd6,
        StStore     = 3'd7
    } phase_e;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;
    logic   is_hlt;
    logic   is_skz;
    logic   is_sto;
    logic   is_jmp;
    logic   hold_for_step;

    assign aluop  = (opcode_i == OpAdd) || (opcode_i == OpAnd) ||
                    (opcode_i == OpXor) || (opcode_i == OpLda);
    assign is_hlt = (opcode_i == OpHlt);
    assign is_skz = (opcode_i == OpSkz);
    assign is_sto = (opcode_i == OpSto);
    assign is_jmp = (opcode_i == OpJmp);

`ifdef VRISC_CTRL_STEP_EN
    assign hold_for_step = (phase_q == StInstAddr) && !step_i;
`else
    assign hold_for_step = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= StInstAddr;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Halting freezes the phase at OP_ADDR; only reset leaves it.
    always_comb begin
        phase_d  = phase_e'(phase_q + 3'd1);
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = phase_q;
        end else if (phase_q == StOpAddr && is_hlt) begin
            halted_d = 1'b1;
            phase_d  = phase_q;
        end else if (hold_for_step) begin
            phase_d = phase_q;
        end
    end

    always_comb begin
        sel_o    = 1'b0;
        rd_o     = 1'b0;
        ld_ir_o  = 1'b0;
        inc_pc_o = 1'b0;
        halt_o   = 1'b0;
        ld_pc_o  = 1'b0;
        data_e_o = 1'b0;
        ld_ac_o  = 1'b0;
        wr_o     = 1'b0;
        if (halted_q) begin
            halt_o = 1'b1;
        end else begin
            unique case (phase_q)
                StInstAddr: begin
                    sel_o = 1'b1;
                end
                StInstFetch: begin
                    sel_o = 1'b1;
                    rd_o  = 1'b1;
                end
                StInstLoad, StIdle: begin
                    sel_o   = 1'b1;
                    rd_o    = 1'b1;
                    ld_ir_o = 1'b1;
                end
                StOpAddr: begin
                    inc_pc_o = 1'b1;
                    halt_o   = is_hlt;
                end
                StOpFetch: begin
                    rd_o = aluop;
                end
                StAluOp: begin
                    rd_o     = aluop;
                    inc_pc_o = is_skz && zero_i;
                    ld_pc_o  = is_jmp;
                    data_e_o = is_sto;
                end
                StStore: begin
                    rd_o     = aluop;
                    ld_ac_o  = aluop;
                    ld_pc_o  = is_jmp;
                    wr_o     = is_sto;
                    data_e_o = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign phase_o = phase_q;

endmodule

// File: tb/tb_vrisc_controller.sv
// Randomized self-checking bench for vrisc_controller against an instruction-level model.
module tb_vrisc_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       step = 1'b1;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [2:0] phase;

    int n_checks = 0;
    int n_errors = 0;
    int m_pos    = 0;
    bit m_halt   = 1'b0;

    vrisc_controller u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode_i (opcode),
        .zero_i   (zero),
`ifdef VRISC_CTRL_STEP_EN
        .step_i   (step),
`endif
        .sel_o    (sel),
        .rd_o     (rd),
        .ld_ir_o  (ld_ir),
        .inc_pc_o (inc_pc),
        .halt_o   (halt),
        .ld_pc_o  (ld_pc),
        .data_e_o (data_e),
        .ld_ac_o  (ld_ac),
        .wr_o     (wr),
        .phase_o  (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (pos=%0d op=%0d t=%0t)",
                     tag, got, exp, m_pos, opcode, $time);
        end
    endtask

    // Strobe vector {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} from the instruction rules.
    function automatic logic [8:0] model_strobes(input int pos, input int op, input bit z,
                                                 input bit h);
        bit alu;
        bit s, r, li, ip, hl, lp, de, la, w;
        alu = (op >= 2 && op <= 5);
        s  = !h && pos <= 3;
        r  = !h && ((pos >= 1 && pos <= 3) || (pos >= 5 && alu));
        li = !h && (pos == 2 || pos == 3);
        ip = !h && (pos == 4 || (pos == 6 && op == 1 && z));
        hl = h || (pos == 4 && op == 0);
        lp = !h && op == 7 && pos >= 6;
        de = !h && op == 6 && pos >= 6;
        la = !h && alu && pos == 7;
        w  = !h && op == 6 && pos == 7;
        return {s, r, li, ip, hl, lp, de, la, w};
    endfunction

    function automatic logic [8:0] dut_strobes();
        return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    endfunction

    task automatic check_now(input string tag);
        check({tag, ".strobes"}, 32'(dut_strobes()),
              32'(model_strobes(m_pos, int'(opcode), zero, m_halt)));
        check({tag, ".phase"}, 32'(phase), 32'(m_pos));
    endtask

    task automatic run_cycle(input string tag, input int op, input bit z);
        opcode = 3'(op);
        zero   = z;
        #1;
        check_now(tag);
        @(posedge clk);
        #1;
        if (!m_halt) begin
            if (m_pos == 4 && op == 0) m_halt = 1'b1;
            else if (!(m_pos == 0 && !step)) m_pos = (m_pos + 1) % 8;
        end
    endtask

    task automatic run_instr(input string tag, input int op, input bit z);
        for (int i = 0; i < 8; i++) run_cycle(tag, op, z);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_pos  = 0;
        m_halt = 1'b0;
        check_now(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        check_now("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("add", 2, 1'b0);
        run_instr("sto", 6, 1'b1);
        run_instr("skz_z1", 1, 1'b1);
        run_instr("skz_z0", 1, 1'b0);
        run_instr("jmp", 7, 1'b0);
        run_instr("and", 3, 1'b1);
        run_instr("xor", 4, 1'b0);
        run_instr("lda", 5, 1'b1);

        for (int n = 0; n < 60; n++) begin
            int op;
            op = int'($urandom_range(7, 1));
            for (int c = 0; c < 8; c++) run_cycle("rand", op, 1'($urandom));
        end

        // Asynchronous reset in the middle of OP_FETCH.
        while (m_pos != 5) run_cycle("to_p5", 6, 1'b0);
        #2;
        apply_reset("rst_mid");
        run_cycle("rel_p0", 2, 1'b0);
        check("rel_p1", 32'(phase), 32'd1);
        for (int c = 0; c < 7; c++) run_cycle("rel", 2, 1'b0);

        for (int c = 0; c < 5; c++) run_cycle("hlt", 0, 1'b0);
        for (int c = 0; c < 20; c++) run_cycle("halted", int'($urandom_range(7, 0)),
                                               1'($urandom));
        check("halt_phase", 32'(phase), 32'd4);
        apply_reset("rst_hlt");
        run_instr("post_hlt", 2, 1'b0);

`ifdef VRISC_CTRL_STEP_EN
        step = 1'b0;
        for (int c = 0; c < 10; c++) run_cycle("step_hold", 2, 1'b0);
        step = 1'b1;
        run_cycle("step_go", 2, 1'b0);
        step = 1'b0;
        for (int c = 0; c < 7; c++) run_cycle("step_run", 2, 1'b0);
        for (int c = 0; c < 4; c++) run_cycle("step_idle", 2, 1'b0);
        check("step_end", 32'(phase), 32'd0);
        step = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
